qpsk_mapper: RTL and testbench
==============================

// Module: qpsk_mapper
// PURPOSE
//  Serial-bit to QPSK symbol mapper; sits directly downstream of the interleaver ping-pong buffer.
//  Consumes the interleaved bit stream (1 bit/cycle, valid/ready) and pairs bits into Gray-coded QPSK I/Q.
//  Emits fixed-point symbols with valid/ready and a last flag, 96 symbols per 192-bit interleaver block.
// PARAMETERS
//  WIDTH          16   I/Q sample width, signed two's complement, Q1.(WIDTH-1)
//  BLOCK_SYMBOLS  96   symbols per block (= 192 interleaved bits / 2)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  bit_in     in   1      interleaved data bit
//  valid_in   in   1      bit_in valid
//  ready_out  out  1      mapper accepts bit_in this cycle
//  i_out      out  WIDTH  in-phase sample
//  q_out      out  WIDTH  quadrature sample
//  valid_out  out  1      i_out/q_out/last_out valid
//  ready_in   in   1      downstream accepts symbol this cycle
//  last_out   out  1      final symbol of block (index BLOCK_SYMBOLS-1)
// BEHAVIOUR
//  Reset: i_out=q_out=0, valid_out=0, last_out=0, pair state=FIRST, symbol counter=0; ready_out=1 after reset release.
//  Bit transfer on valid_in && ready_out; symbol transfer on valid_out && ready_in.
//  Mapping: first bit of pair -> I, second -> Q; bit 0 -> +QPSK_AMP, bit 1 -> -QPSK_AMP.
//   QPSK_AMP = round(0.7071*2^(WIDTH-1)) = 23170 (0x5A82) at WIDTH=16; negative = -23170 (0xA57E).
//  FSM (pair state): FIRST  -> accept bit, store in b0_reg, go SECOND.
//                    SECOND -> accept bit, load output register {I from b0_reg, Q from bit_in}, go FIRST.
//  Output register: one symbol deep; valid_out set on load, cleared on transfer without new load.
//  ready_out = (state==FIRST) || !valid_out || ready_in (combinational path from ready_in is intentional).
//  Load and drain in same cycle: output register takes new symbol, valid_out stays 1.
//  Latency: symbol visible on outputs the cycle after its second bit is accepted.
//  Throughput: 1 symbol / 2 cycles sustained with ready_in=1; no bubbles inserted by the mapper.
//  Gaps: valid_in low in FIRST or SECOND holds state indefinitely; b0_reg retained across gaps.
//  Backpressure: i_out/q_out/last_out held stable while valid_out && !ready_in.
//  Symbol counter: increments on each symbol load, wraps BLOCK_SYMBOLS-1 -> 0; last_out=1 for symbol loaded at count BLOCK_SYMBOLS-1.
//  Counter width: $clog2(BLOCK_SYMBOLS); no other arithmetic (constants only, no multipliers).
//  Reset mid-pair or mid-block: half-pair and pending symbol discarded, counter to 0, next accepted bit is an I bit.
//  valid_in while ready_out=0: bit not consumed; upstream must hold it (standard valid/ready).
// STRUCTURE
//  Shared package wimax_pkg: BLOCK_BITS=192, QPSK_AMP constant, pair_state_t enum {FIRST, SECOND}.
//  One natural sub-module: qpsk_symbol_lut (combinational 2-bit -> {I,Q} map), reused by later 16/64-QAM mappers.
//  Top holds FSM, b0_reg, output register, symbol counter.
// TESTING
//  1. Bits 0,0 / 0,1 / 1,0 / 1,1, ready_in=1 -> (I,Q)=(+23170,+23170),(+23170,-23170),(-23170,+23170),(-23170,-23170), each 1 cycle after 2nd bit.
//  2. 192 bits back-to-back, ready_in=1 -> 96 symbols, valid_out every 2nd cycle, last_out only on 96th; next block restarts at index 0.
//  3. ready_in=0 for 10 cycles with symbol pending -> outputs stable, exactly one more bit (I) accepted then ready_out=0; release -> no loss/duplication.
//  4. valid_in gap of 5 cycles between I and Q bits -> symbol produced with correct I from held bit; no spurious valid_out.
//  5. Assert reset after 1 bit of symbol 40 -> all outputs 0, next 2 bits form symbol index 0, last_out after 96 further symbols.
//  6. Random valid_in/ready_in (50%) over 10 blocks -> scoreboard matches reference mapping, last_out every 96th symbol, zero drops.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY constants and types: interleaver block size, QPSK amplitude, mapper pair state.
// Pure declarations; no timing or flow control.
package wimax_pkg;

  localparam int BLOCK_BITS = 192;

  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} pair_state_t;

  // round(0.7071 * 2^(width-1)), evaluated at elaboration only
  function automatic longint qpsk_amp(input int width);
    return (longint'(7071) * (longint'(1) << (width - 1)) + longint'(5000)) / longint'(10000);
  endfunction

  localparam int QPSK_AMP = int'(qpsk_amp(16));

endpackage

// File: rtl/qpsk_symbol_lut.sv
// Combinational Gray map of a bit pair {b_i, b_q} to QPSK I/Q; bit 0 -> +amp, bit 1 -> -amp.
// Zero latency, no flow control.
module qpsk_symbol_lut
  import wimax_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       bits,
  output logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] q_val
);

  localparam logic [WIDTH-1:0] POS = WIDTH'(qpsk_amp(WIDTH));
  localparam logic [WIDTH-1:0] NEG = WIDTH'(-qpsk_amp(WIDTH));

  always_comb begin
    i_val = bits[1] ? NEG : POS;
    q_val = bits[0] ? NEG : POS;
  end

endmodule

// File: rtl/qpsk_mapper.sv
// Serial bit to QPSK symbol mapper; symbol appears the cycle after its second bit is accepted.
// One-deep output register; ready_out drops only while holding a half pair behind a stalled symbol.
module qpsk_mapper
  import wimax_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int BLOCK_SYMBOLS = BLOCK_BITS / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] q_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             last_out
);

  localparam int CNT_W = $clog2(BLOCK_SYMBOLS);

  pair_state_t      state;
  logic             b0_reg;
  logic [CNT_W-1:0] sym_cnt;
  logic             bit_xfer;
  logic             sym_xfer;
  logic             load;
  logic             cnt_wrap;
  logic [WIDTH-1:0] lut_i;
  logic [WIDTH-1:0] lut_q;

  // A first bit can always be parked in b0_reg, so FIRST never blocks upstream
  assign ready_out = (state == FIRST) || !valid_out || ready_in;
  assign bit_xfer  = valid_in && ready_out;
  assign sym_xfer  = valid_out && ready_in;
  assign load      = bit_xfer && (state == SECOND);
  assign cnt_wrap  = (sym_cnt == CNT_W'(BLOCK_SYMBOLS - 1));

  qpsk_symbol_lut #(
    .WIDTH (WIDTH)
  ) u_lut (
    .bits  ({b0_reg, bit_in}),
    .i_val (lut_i),
    .q_val (lut_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FIRST;
      b0_reg <= 1'b0;
    end else if (bit_xfer) begin
      if (state == FIRST) begin
        b0_reg <= bit_in;
        state  <= SECOND;
      end else begin
        state  <= FIRST;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_out     <= '0;
      q_out     <= '0;
      last_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (load) begin
      i_out     <= lut_i;
      q_out     <= lut_q;
      last_out  <= cnt_wrap;
      valid_out <= 1'b1;
    end else if (sym_xfer) begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt <= '0;
    end else if (load) begin
      sym_cnt <= cnt_wrap ? '0 : sym_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed and random bench for qpsk_mapper with a per-cycle reference model and symbol scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_qpsk_mapper;

  localparam logic [15:0] POS = 16'h5A82;
  localparam logic [15:0] NEG = 16'hA57E;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;
  logic        ready_out;
  logic        valid_out;
  logic        last_out;
  logic [15:0] i_out;
  logic [15:0] q_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpsk_mapper #(
    .WIDTH         (16),
    .BLOCK_SYMBOLS (96)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .i_out     (i_out),
    .q_out     (q_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] amp(input logic b);
    return b ? NEG : POS;
  endfunction

  // Reference model: pair state, expected symbol queue {last, I, Q}, block index
  bit          half = 1'b0;
  logic        b0 = 1'b0;
  int          exp_idx = 0;
  logic [32:0] expq[$];
  bit          stall = 1'b0;
  logic [32:0] prev = '0;
  bit          acc_flag = 1'b0;
  int          n_sym = 0;
  int          n_last = 0;

  always @(negedge clk) begin : model
    logic [32:0] front;
    acc_flag = 1'b0;
    if (reset) begin
      half    = 1'b0;
      exp_idx = 0;
      stall   = 1'b0;
      expq.delete();
    end else begin
      check("ready_out", 32'(ready_out), 32'(!half || expq.size() == 0 || ready_in));
      check("valid_out", 32'(valid_out), 32'(expq.size() != 0));
      if (stall) begin
        check("hold_i", 32'(i_out), 32'(prev[31:16]));
        check("hold_q", 32'(q_out), 32'(prev[15:0]));
        check("hold_last", 32'(last_out), 32'(prev[32]));
      end
      if (valid_out && ready_in && expq.size() != 0) begin
        front = expq.pop_front();
        check("sym_i", 32'(i_out), 32'(front[31:16]));
        check("sym_q", 32'(q_out), 32'(front[15:0]));
        check("sym_last", 32'(last_out), 32'(front[32]));
        n_sym++;
        if (last_out) n_last++;
      end
      stall = valid_out && !ready_in;
      prev  = {last_out, i_out, q_out};
      if (valid_in && ready_out) begin
        acc_flag = 1'b1;
        if (!half) begin
          b0   = bit_in;
          half = 1'b1;
        end else begin
          expq.push_back({exp_idx == 95, amp(b0), amp(bit_in)});
          exp_idx = (exp_idx == 95) ? 0 : exp_idx + 1;
          half = 1'b0;
        end
      end
    end
  end

  // Present a bit and hold it until accepted; cyc returns the cycles taken
  task automatic send_bit(input logic b, output int cyc);
    bit_in   = b;
    valid_in = 1'b1;
    cyc      = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc_flag) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, tot, n, s0, l0, sent;
    logic [1:0] pv;
    logic [15:0] t1_i[4];
    logic [15:0] t1_q[4];
    t1_i = '{POS, POS, NEG, NEG};
    t1_q = '{POS, NEG, POS, NEG};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_i", 32'(i_out), 32'd0);
    check("rst_q", 32'(q_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_last", 32'(last_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", 32'(ready_out), 32'd1);

    // 1: all four bit pairs, one cycle after the second bit
    for (int k = 0; k < 4; k++) begin
      pv = 2'(k);
      send_bit(pv[1], cyc);
      send_bit(pv[0], cyc);
      check("t1_valid", 32'(valid_out), 32'd1);
      check("t1_i", 32'(i_out), 32'(t1_i[k]));
      check("t1_q", 32'(q_out), 32'(t1_q[k]));
    end
    idle(2);

    // 2: full block back-to-back, then the next block restarts at index 0
    do_reset();
    s0 = n_sym;
    l0 = n_last;
    tot = 0;
    for (int k = 0; k < 192; k++) begin
      send_bit(1'($urandom_range(0, 1)), cyc);
      tot += cyc;
    end
    check("t2_cycles", 32'(tot), 32'd192);
    check("t2_last_on_96", 32'(last_out), 32'd1);
    for (int k = 0; k < 4; k++) send_bit(1'(k), cyc);
    check("t2_next_not_last", 32'(last_out), 32'd0);
    idle(3);
    check("t2_n_last", 32'(n_last - l0), 32'd1);
    check("t2_n_sym", 32'(n_sym - s0), 32'd98);

    // 3: backpressure with a symbol pending
    s0 = n_sym;
    ready_in = 1'b0;
    send_bit(1'b1, cyc);
    send_bit(1'b0, cyc);
    check("t3_i", 32'(i_out), 32'(NEG));
    check("t3_q", 32'(q_out), 32'(POS));
    bit_in = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (acc_flag) n++;
    end
    check("t3_accepted", 32'(n), 32'd1);
    check("t3_ready_low", 32'(ready_out), 32'd0);
    check("t3_i_held", 32'(i_out), 32'(NEG));
    ready_in = 1'b1;
    send_bit(1'b1, cyc);
    check("t3_i2", 32'(i_out), 32'(NEG));
    check("t3_q2", 32'(q_out), 32'(NEG));
    idle(3);
    check("t3_n_sym", 32'(n_sym - s0), 32'd2);

    // 4: gap between I and Q bits
    send_bit(1'b0, cyc);
    valid_in = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("t4_no_valid", 32'(valid_out), 32'd0);
    end
    send_bit(1'b1, cyc);
    check("t4_valid", 32'(valid_out), 32'd1);
    check("t4_i", 32'(i_out), 32'(POS));
    check("t4_q", 32'(q_out), 32'(NEG));
    idle(2);

    // 5: reset after the first bit of symbol 40
    do_reset();
    for (int k = 0; k < 81; k++) send_bit(1'($urandom_range(0, 1)), cyc);
    valid_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_i", 32'(i_out), 32'd0);
    check("t5_rst_q", 32'(q_out), 32'd0);
    check("t5_rst_valid", 32'(valid_out), 32'd0);
    check("t5_rst_last", 32'(last_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    s0 = n_sym;
    l0 = n_last;
    for (int k = 0; k < 192; k++) send_bit(1'($urandom_range(0, 1)), cyc);
    check("t5_last_on_96", 32'(last_out), 32'd1);
    idle(2);
    check("t5_n_last", 32'(n_last - l0), 32'd1);
    check("t5_n_sym", 32'(n_sym - s0), 32'd96);

    // 6: random valid/ready over 10 blocks
    s0 = n_sym;
    l0 = n_last;
    sent = 0;
    for (int c = 0; c < 20000; c++) begin
      if (!(valid_in && !acc_flag)) begin
        valid_in = 1'($urandom_range(0, 1));
        bit_in   = 1'($urandom_range(0, 1));
      end
      ready_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (acc_flag) sent++;
      if (sent == 1920) break;
    end
    check("t6_bits_sent", 32'(sent), 32'd1920);
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int c = 0; c < 20 && expq.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("t6_drained", 32'(expq.size()), 32'd0);
    check("t6_n_sym", 32'(n_sym - s0), 32'd960);
    check("t6_n_last", 32'(n_last - l0), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
